dpi_flow_ctx_ctrl: RTL
======================

Name: dpi_flow_ctx_ctrl

Overview:
- Upstream feeder for one DFA regex matcher in the DPI core; sits between the packet byte stream and the matcher.
- Per packet, looks up the flow's saved DFA state and loads it into the matcher, then streams the payload bytes at one byte per cycle.
- At end of packet, captures the matcher state and writes it back, so a pattern split across packets of one flow still matches.
- Registers every accept pulse as a match report carrying flow ID and byte offset.

Parameters:
FLOW_W, 6, flow ID width; context table holds 2**FLOW_W entries
STATE_W, 11, DFA state width; must equal the matcher state width
OFF_W, 16, width of the match byte-offset field

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
pkt_vld  in  1  input byte valid
pkt_sop  in  1  byte is first of packet
pkt_eop  in  1  byte is last of packet
pkt_data  in  8  payload byte
pkt_flow  in  FLOW_W  flow ID; sampled only on the sop beat
pkt_rdy  out  1  byte accepted when pkt_vld&pkt_rdy
dfa_char  out  8  to matcher char_in
dfa_char_vld  out  1  to matcher char_in_vld
dfa_state_in  out  STATE_W  to matcher state_in
dfa_state_in_vld  out  1  to matcher state_in_vld
dfa_state_out  in  STATE_W  from matcher state_out
dfa_accept  in  1  from matcher accept_out (combinational)
ctx_clr  in  1  clear one flow's context (new connection)
ctx_clr_flow  in  FLOW_W  flow to clear
match_vld  out  1  one-cycle match report
match_flow  out  FLOW_W  flow of the match
match_off  out  OFF_W  0-based byte offset in packet of the accepting byte
proto_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset, asynchronous on rst_n low:
  - FSM returns to IDLE.
  - All context entries are cleared to 0.
  - Every output is 0.
  - Reset mid-packet discards the packet; no save is performed.
- FSM states: IDLE, RESTORE, STREAM, SAVE.
- IDLE:
  - pkt_rdy=0 while a sop beat is presented.
  - A sop beat latches pkt_flow into cur_flow and moves to RESTORE.
  - A non-sop beat gets pkt_rdy=1, is discarded, and pulses proto_err.
- RESTORE (1 cycle):
  - dfa_state_in=ctx[cur_flow], dfa_state_in_vld=1, pkt_rdy=0.
  - Clears the byte offset and goes to STREAM.
- STREAM:
  - pkt_rdy=1, except for sop beats.
  - dfa_char=pkt_data; dfa_char_vld=pkt_vld&pkt_rdy. dfa_char is combinational, so the matcher sees the byte in the same cycle.
  - Each accepted byte increments the offset; the offset saturates at all-ones.
  - An accepted eop byte moves to SAVE.
  - A sop beat arriving in STREAM is not accepted: pulse proto_err, go to SAVE, and the held sop beat is served afterwards.
- SAVE (1 cycle):
  - ctx[cur_flow]<=dfa_state_out. The matcher updated on the eop edge, so its output is valid here.
  - If pkt_vld&pkt_sop, latch the new flow and go directly to RESTORE; else go to IDLE.
- Throughput: one byte per cycle in STREAM; 2 overhead cycles per back-to-back packet.
- Match reporting:
  - When dfa_char_vld&dfa_accept, register match_vld=1 on the next cycle, with match_flow=cur_flow and match_off=offset of that byte.
  - Latency is 1 cycle; no backpressure on match reports.
- ctx_clr:
  - Writes 0 to ctx[ctx_clr_flow] on the next edge.
  - If ctx_clr_flow==cur_flow while in RESTORE, STREAM or SAVE, set a clr_pend flag; the SAVE then writes 0 instead of dfa_state_out, and clr_pend clears.
  - A clear in the same cycle as SAVE to the same flow: the clear wins.
  - A clear in the RESTORE cycle for cur_flow: 0 is loaded (bypass).
- dfa_state_in_vld and dfa_char_vld are never high together.

Decomposition:
- Shared package dpi_pkg:
  - STATE_W and FLOW_W defaults.
  - FSM state encoding constants for IDLE, RESTORE, STREAM and SAVE.
  - Match record field widths.
- Sub-module dpi_flow_ctx_ram:
  - 2**FLOW_W x STATE_W register array.
  - One async read port; one write port with clear priority.
  - Asynchronous reset to 0.

Test Plan:
The bench instantiates the USER\s+W0RM matcher; letters are case-insensitive.
1. Flow 3, one packet "USER w0rm" -> match_vld once, match_flow=3, match_off=8; afterwards ctx[3]=0.
2. Flow 3 "USER w", then flow 3 "0rM" -> no match in packet 1, saved ctx[3]=8; match in packet 2, match_off=2.
3. Flow 3 "USER", flow 5 "xx", flow 3 " W0RM", all back-to-back -> exactly one match, flow 3, match_off=4; pkt_rdy low exactly 2 cycles between packets.
4. Flow 3 "USER w", ctx_clr for flow 3, then flow 3 "0rm" -> no match_vld.
5. ctx_clr for flow 3 in the SAVE cycle of flow 3's "USER" packet -> ctx[3]=0.
6. Non-sop byte in IDLE -> proto_err pulse, byte consumed. sop beat mid-packet -> proto_err, previous flow saved, new packet restored and streamed. rst_n low mid-STREAM -> all outputs 0 asynchronously, all contexts 0.

Source files
------------

// File: rtl/dpi_pkg.sv
// Shared defaults, FSM encoding and match-record widths for the DPI flow-context feeder.
package dpi_pkg;

    localparam int FLOW_W_DEF  = 6;
    localparam int STATE_W_DEF = 11;
    localparam int OFF_W_DEF   = 16;

    localparam int MATCH_FLOW_W = FLOW_W_DEF;
    localparam int MATCH_OFF_W  = OFF_W_DEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        STREAM  = 2'd2,
        SAVE    = 2'd3
    } ctx_fsm_e;

endpackage

// File: rtl/dpi_flow_ctx_ram.sv
// Per-flow saved DFA state. Asynchronous read; a clear to an entry overrides
// a same-cycle write to that entry, while writes to other entries still land.
module dpi_flow_ctx_ram
    import dpi_pkg::*;
#(
    parameter int FLOW_W  = FLOW_W_DEF,
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOW_W-1:0]  rd_addr,
    output logic [STATE_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [FLOW_W-1:0]  wr_addr,
    input  logic [STATE_W-1:0] wr_data,
    input  logic               clr_en,
    input  logic [FLOW_W-1:0]  clr_addr
);

    localparam int DEPTH = 1 << FLOW_W;

    logic [STATE_W-1:0] mem [DEPTH];

    assign rd_data = mem[rd_addr];

    // Entry update: clear beats save, everything returns to the start state on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr_en && (clr_addr == FLOW_W'(i))) begin
                    mem[i] <= '0;
                end else if (wr_en && (wr_addr == FLOW_W'(i))) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/dpi_flow_ctx_ctrl.sv
// Feeds one DFA matcher from the packet byte stream: restores the flow's saved
// DFA state at start of packet, streams bytes, saves the state at end of packet
// and turns accept pulses into registered match reports.
module dpi_flow_ctx_ctrl
    import dpi_pkg::*;
#(
    parameter int FLOW_W  = FLOW_W_DEF,
    parameter int STATE_W = STATE_W_DEF,
    parameter int OFF_W   = OFF_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_vld,
    input  logic               pkt_sop,
    input  logic               pkt_eop,
    input  logic [7:0]         pkt_data,
    input  logic [FLOW_W-1:0]  pkt_flow,
    output logic               pkt_rdy,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state_in,
    output logic               dfa_state_in_vld,
    input  logic [STATE_W-1:0] dfa_state_out,
    input  logic               dfa_accept,
    input  logic               ctx_clr,
    input  logic [FLOW_W-1:0]  ctx_clr_flow,
    output logic               match_vld,
    output logic [FLOW_W-1:0]  match_flow,
    output logic [OFF_W-1:0]   match_off,
    output logic               proto_err
);

    ctx_fsm_e           state;
    ctx_fsm_e           state_nxt;
    logic [FLOW_W-1:0]  cur_flow;
    logic [OFF_W-1:0]   offset;
    logic               clr_pend;
    logic               clr_hit;
    logic               latch_flow;
    logic               first_beat;
    logic [STATE_W-1:0] ctx_rd_data;
    logic [STATE_W-1:0] ctx_wr_data;

    // The offset only returns to zero in RESTORE (it saturates), so zero means
    // no byte of this packet has been taken yet and the held sop beat is legal.
    assign first_beat  = (offset == '0);
    assign clr_hit     = ctx_clr && (ctx_clr_flow == cur_flow);
    assign ctx_wr_data = clr_pend ? '0 : dfa_state_out;

    dpi_flow_ctx_ram #(
        .FLOW_W  (FLOW_W),
        .STATE_W (STATE_W)
    ) u_ctx_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (cur_flow),
        .rd_data  (ctx_rd_data),
        .wr_en    (state == SAVE),
        .wr_addr  (cur_flow),
        .wr_data  (ctx_wr_data),
        .clr_en   (ctx_clr),
        .clr_addr (ctx_clr_flow)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake/matcher outputs; everything is held at 0 while in reset.
    always_comb begin
        state_nxt        = state;
        pkt_rdy          = 1'b0;
        dfa_char         = '0;
        dfa_char_vld     = 1'b0;
        dfa_state_in     = '0;
        dfa_state_in_vld = 1'b0;
        proto_err        = 1'b0;
        latch_flow       = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (pkt_vld && pkt_sop) begin
                        latch_flow = 1'b1;
                        state_nxt  = RESTORE;
                    end else if (pkt_vld) begin
                        pkt_rdy   = 1'b1;
                        proto_err = 1'b1;
                    end
                end
                RESTORE: begin
                    dfa_state_in     = clr_hit ? '0 : ctx_rd_data;
                    dfa_state_in_vld = 1'b1;
                    state_nxt        = STREAM;
                end
                STREAM: begin
                    dfa_char = pkt_data;
                    if (pkt_sop && !first_beat) begin
                        if (pkt_vld) begin
                            proto_err = 1'b1;
                            state_nxt = SAVE;
                        end
                    end else begin
                        pkt_rdy      = 1'b1;
                        dfa_char_vld = pkt_vld;
                        if (pkt_vld && pkt_eop) begin
                            state_nxt = SAVE;
                        end
                    end
                end
                SAVE: begin
                    if (pkt_vld && pkt_sop) begin
                        latch_flow = 1'b1;
                        state_nxt  = RESTORE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Current flow, byte offset and the pending-clear flag for the flow in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_flow <= '0;
            offset   <= '0;
            clr_pend <= 1'b0;
        end else begin
            if (latch_flow) begin
                cur_flow <= pkt_flow;
            end
            if (state == RESTORE) begin
                offset <= '0;
            end else if (dfa_char_vld && (offset != '1)) begin
                offset <= offset + 1'b1;
            end
            if ((state == SAVE) || (state == IDLE)) begin
                clr_pend <= 1'b0;
            end else if (clr_hit) begin
                clr_pend <= 1'b1;
            end
        end
    end

    // Registered match report, one cycle after the accepting byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_vld  <= 1'b0;
            match_flow <= '0;
            match_off  <= '0;
        end else begin
            match_vld <= dfa_char_vld && dfa_accept;
            if (dfa_char_vld && dfa_accept) begin
                match_flow <= cur_flow;
                match_off  <= offset;
            end
        end
    end

endmodule
